// File: rtl/stage_pkg.sv
// Shared definitions for the elastic pipeline stage: state encoding and
// the mapping from state to live entry count.
package stage_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } stage_state_e;

  // Number of live entries held in a given state.
  function automatic logic [1:0] state_occupancy(input stage_state_e s);
    logic [1:0] occ;
    case (s)
      EMPTY:   occ = 2'd0;
      BUSY:    occ = 2'd1;
      FULL:    occ = 2'd2;
      default: occ = 2'd0;
    endcase
    return occ;
  endfunction

endpackage

// File: rtl/elastic_stage.sv
// Valid/ready elastic pipeline stage. With SKID_EN=1 it is a two-entry skid
// buffer whose in_ready comes straight from a flop; with SKID_EN=0 it is a
// single register whose in_ready looks through to out_ready.
module elastic_stage
  import stage_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter bit SKID_EN = 1'b1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic [1:0]       occupancy
);

  stage_state_e     state_q, state_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic             valid_q;
  logic             skid_load;
  logic [WIDTH-1:0] skid_val;
  logic             in_fire;
  logic             out_fire;

  assign in_fire  = in_valid && in_ready;
  assign out_fire = valid_q && out_ready;

  // Next-state and main-register selection; flush overrides everything and
  // only clears validity, leaving the data registers as they were.
  always_comb begin
    state_d   = state_q;
    main_d    = main_q;
    skid_load = 1'b0;
    case (state_q)
      EMPTY: begin
        if (in_fire) begin
          state_d = BUSY;
          main_d  = in_data;
        end
      end
      BUSY: begin
        if (in_fire && out_fire) begin
          main_d = in_data;
        end else if (in_fire) begin
          // Only reachable with a skid register: without one, in_ready in
          // BUSY already implies out_ready.
          if (SKID_EN) begin
            state_d   = FULL;
            skid_load = 1'b1;
          end
        end else if (out_fire) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (out_fire) begin
          state_d = BUSY;
          main_d  = skid_val;
        end
      end
      default: state_d = EMPTY;
    endcase
    if (flush) begin
      state_d   = EMPTY;
      main_d    = main_q;
      skid_load = 1'b0;
    end
  end

  // State, main register and registered out_valid.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= EMPTY;
      main_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      valid_q <= (state_d != EMPTY);
    end
  end

  generate
    if (SKID_EN) begin : g_skid
      logic [WIDTH-1:0] skid_q;
      logic             full_q;

      // Skid register and registered FULL flag feeding in_ready.
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          skid_q <= '0;
          full_q <= 1'b0;
        end else begin
          if (skid_load) begin
            skid_q <= in_data;
          end
          full_q <= (state_d == FULL);
        end
      end

      assign skid_val = skid_q;
      assign in_ready = !full_q;
    end else begin : g_noskid
      assign skid_val = '0;
      assign in_ready = !valid_q || out_ready;
    end
  endgenerate

  assign out_valid = valid_q;
  assign out_data  = main_q;
  assign occupancy = state_occupancy(state_q);

endmodule

// File: tb/tb_elastic_stage.sv
// Bench for elastic_stage: one skid instance and one single-entry instance,
// each shadowed by a queue model of the valid/ready contract.
module tb_elastic_stage;

  localparam int W = 8;

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  logic         s_flush = 0, s_in_valid = 0, s_out_ready = 0;
  logic [W-1:0] s_in_data = '0;
  logic         s_in_ready, s_out_valid;
  logic [W-1:0] s_out_data;
  logic [1:0]   s_occ;

  logic         n_flush = 0, n_in_valid = 0, n_out_ready = 0;
  logic [W-1:0] n_in_data = '0;
  logic         n_in_ready, n_out_valid;
  logic [W-1:0] n_out_data;
  logic [1:0]   n_occ;

  int total = 0;
  int passed = 0;

  logic [W-1:0] mq_s[$];
  logic [W-1:0] mq_n[$];

  always #5 clk = ~clk;

  elastic_stage #(.WIDTH(W), .SKID_EN(1'b1)) u_skid (
    .clk(clk), .reset_n(reset_n), .flush(s_flush),
    .in_valid(s_in_valid), .in_data(s_in_data), .in_ready(s_in_ready),
    .out_valid(s_out_valid), .out_data(s_out_data), .out_ready(s_out_ready),
    .occupancy(s_occ)
  );

  elastic_stage #(.WIDTH(W), .SKID_EN(1'b0)) u_noskid (
    .clk(clk), .reset_n(reset_n), .flush(n_flush),
    .in_valid(n_in_valid), .in_data(n_in_data), .in_ready(n_in_ready),
    .out_valid(n_out_valid), .out_data(n_out_data), .out_ready(n_out_ready),
    .occupancy(n_occ)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model, skid mode: up to two entries, accept while not full.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mq_s.delete();
    end else if (s_flush) begin
      mq_s.delete();
    end else begin
      bit in_acc, out_acc;
      in_acc  = s_in_valid && (mq_s.size() < 2);
      out_acc = (mq_s.size() > 0) && s_out_ready;
      if (out_acc) $display("skid   out %02h", mq_s.pop_front());
      if (in_acc) mq_s.push_back(s_in_data);
    end
  end

  // Reference model, single-entry mode: accept when empty or draining.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mq_n.delete();
    end else if (n_flush) begin
      mq_n.delete();
    end else begin
      bit in_acc, out_acc;
      in_acc  = n_in_valid && ((mq_n.size() == 0) || n_out_ready);
      out_acc = (mq_n.size() > 0) && n_out_ready;
      if (out_acc) $display("noskid out %02h", mq_n.pop_front());
      if (in_acc) mq_n.push_back(n_in_data);
    end
  end

  // Every cycle, on the falling edge, compare both DUTs to the models.
  always @(negedge clk) begin
    if (!reset_n) begin
      chk("rst_s_valid", s_out_valid, 0);
      chk("rst_s_data", s_out_data, 0);
      chk("rst_s_occ", s_occ, 0);
      chk("rst_s_ready", s_in_ready, 1);
      chk("rst_n_valid", n_out_valid, 0);
      chk("rst_n_data", n_out_data, 0);
      chk("rst_n_occ", n_occ, 0);
      chk("rst_n_ready", n_in_ready, 1);
    end else begin
      chk("s_valid", s_out_valid, (mq_s.size() > 0));
      chk("s_occ", s_occ, mq_s.size());
      chk("s_ready", s_in_ready, (mq_s.size() < 2));
      if (mq_s.size() > 0) chk("s_data", s_out_data, mq_s[0]);
      chk("n_valid", n_out_valid, (mq_n.size() > 0));
      chk("n_occ", n_occ, mq_n.size());
      chk("n_ready", n_in_ready, (mq_n.size() == 0) || n_out_ready);
      if (mq_n.size() > 0) chk("n_data", n_out_data, mq_n[0]);
    end
  end

  initial begin
    #1;
    chk("por_s_valid", s_out_valid, 0);
    chk("por_s_ready", s_in_ready, 1);
    #21 reset_n = 1'b1;
    step();

    // Back-to-back stream, out_ready high.
    s_out_ready = 1;
    s_in_valid = 1; s_in_data = 8'h11; step();
    chk("stream1_data", s_out_data, 8'h11); chk("stream1_occ", s_occ, 1);
    s_in_data = 8'h22; step();
    chk("stream2_data", s_out_data, 8'h22); chk("stream2_occ", s_occ, 1);
    s_in_data = 8'h33; step();
    chk("stream3_data", s_out_data, 8'h33); chk("stream3_occ", s_occ, 1);
    s_in_valid = 0; step();
    chk("stream_drain_valid", s_out_valid, 0);

    // Backpressure into the skid register.
    s_out_ready = 0;
    s_in_valid = 1; s_in_data = 8'hA0; step();
    chk("bp_busy_ready", s_in_ready, 1);
    s_in_data = 8'hB1; step();
    chk("bp_full_ready", s_in_ready, 0); chk("bp_full_occ", s_occ, 2);
    chk("bp_full_data", s_out_data, 8'hA0);
    s_in_valid = 0; s_out_ready = 1; step();
    chk("bp_second_data", s_out_data, 8'hB1); chk("bp_second_occ", s_occ, 1);
    step();
    chk("bp_drained", s_out_valid, 0);

    // Flush from FULL with a simultaneous input.
    s_out_ready = 0;
    s_in_valid = 1; s_in_data = 8'hD1; step();
    s_in_data = 8'hD2; step();
    chk("fl_pre_occ", s_occ, 2);
    s_flush = 1; s_in_data = 8'hCC; step();
    chk("fl_valid", s_out_valid, 0); chk("fl_occ", s_occ, 0);
    s_flush = 0; s_in_valid = 0; s_out_ready = 1; step();
    chk("fl_no_cc", s_out_valid, 0);

    // Reset pulse mid-operation, then transfer on first edge after release.
    s_out_ready = 0;
    s_in_valid = 1; s_in_data = 8'h5A; step();
    s_in_valid = 0;
    chk("rm_pre_data", s_out_data, 8'h5A);
    #2 reset_n = 1'b0;
    #1;
    chk("rm_valid", s_out_valid, 0); chk("rm_data", s_out_data, 0);
    chk("rm_occ", s_occ, 0);
    s_in_valid = 1; s_in_data = 8'h66;
    #2 reset_n = 1'b1;
    step();
    chk("rm_first_valid", s_out_valid, 1); chk("rm_first_data", s_out_data, 8'h66);
    s_in_valid = 0; s_out_ready = 1; step();
    chk("rm_drained", s_out_valid, 0);

    // Single-entry mode: in_ready follows out_ready combinationally.
    n_out_ready = 0;
    n_in_valid = 1; n_in_data = 8'h44; step();
    n_in_data = 8'h55; #1;
    chk("ns_blocked_ready", n_in_ready, 0);
    n_out_ready = 1; n_in_data = 8'h77; #1;
    chk("ns_open_ready", n_in_ready, 1);
    step();
    chk("ns_data", n_out_data, 8'h77); chk("ns_occ", n_occ, 1);
    n_in_valid = 0; step();
    chk("ns_drained", n_out_valid, 0);

    // Random valid/ready traffic on both instances.
    for (int i = 0; i < 400; i++) begin
      s_in_valid  = ($urandom_range(0, 3) != 0);
      s_in_data   = W'($urandom);
      s_out_ready = ($urandom_range(0, 2) != 0);
      s_flush     = ($urandom_range(0, 40) == 0);
      n_in_valid  = ($urandom_range(0, 3) != 0);
      n_in_data   = W'($urandom);
      n_out_ready = ($urandom_range(0, 2) != 0);
      n_flush     = ($urandom_range(0, 40) == 0);
      step();
    end
    s_in_valid = 0; s_flush = 0; s_out_ready = 1;
    n_in_valid = 0; n_flush = 0; n_out_ready = 1;
    step(); step(); step();
    chk("end_s_empty", s_out_valid, 0);
    chk("end_n_empty", n_out_valid, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
